// File: rtl/ctrl_pkg.sv
// Shared control-bundle types, opcode constants and the bubble value for the
// RV32I instruction-decode stage.
package ctrl_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5,
        IMM_NONE = 3'd7
    } imm_type_e;

    typedef enum logic [1:0] {
        ALU_MEM    = 2'b00,
        ALU_BRANCH = 2'b01,
        ALU_RTYPE  = 2'b10,
        ALU_ITYPE  = 2'b11
    } aluop_e;

    typedef enum logic [1:0] {
        RD_ALU = 2'b00,
        RD_MEM = 2'b01,
        RD_PC4 = 2'b10,
        RD_IMM = 2'b11
    } rd_src_e;

    localparam logic [1:0] ST_NONE = 2'b00;
    localparam logic [1:0] ST_SB   = 2'b01;
    localparam logic [1:0] ST_SH   = 2'b10;
    localparam logic [1:0] ST_SW   = 2'b11;

    localparam logic [2:0] LD_NONE = 3'b000;
    localparam logic [2:0] LD_LB   = 3'b001;
    localparam logic [2:0] LD_LH   = 3'b010;
    localparam logic [2:0] LD_LBU  = 3'b011;
    localparam logic [2:0] LD_LHU  = 3'b100;
    localparam logic [2:0] LD_LW   = 3'b101;

    typedef struct packed {
        imm_type_e  imm_type;
        logic       jump;
        logic       branch;
        logic       jalr;
        logic       mem_read;
        logic [3:0] mem_web;
        logic       alu_src;
        logic       reg_write;
        aluop_e     aluop;
        logic       mul_op;
        rd_src_e    rd_src;
        logic       pc_imm;
        logic       chip_sel;
        logic       branch_inv;
        logic [1:0] store;
        logic [2:0] load;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '{
        imm_type:   IMM_NONE,
        jump:       1'b0,
        branch:     1'b0,
        jalr:       1'b0,
        mem_read:   1'b0,
        mem_web:    4'b1111,
        alu_src:    1'b0,
        reg_write:  1'b0,
        aluop:      ALU_MEM,
        mul_op:     1'b0,
        rd_src:     RD_ALU,
        pc_imm:     1'b0,
        chip_sel:   1'b0,
        branch_inv: 1'b0,
        store:      ST_NONE,
        load:       LD_NONE
    };

endpackage

// File: rtl/ctrl_decode.sv
// Combinational RV32I control decode: instruction -> {ctrl_t, illegal, uses_rs1, uses_rs2}.
// Define CTRL_MEXT_EN to accept the M-extension funct7 (0000001) on the OP opcode.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [31:0] inst,
    output ctrl_t       ctrl,
    output logic        illegal,
    output logic        uses_rs1,
    output logic        uses_rs2
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_ok;

    assign opcode    = inst[6:0];
    assign funct3    = inst[14:12];
    assign funct7    = inst[31:25];
    assign unused_ok = ^{inst[24:15], inst[11:7]};

    always_comb begin
        ctrl     = CTRL_BUBBLE;
        illegal  = 1'b0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                ctrl.imm_type  = IMM_U;
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.aluop     = ALU_RTYPE;
                ctrl.rd_src    = RD_IMM;
                ctrl.pc_imm    = (opcode == OPC_AUIPC);
            end
            OPC_JAL: begin
                ctrl.imm_type  = IMM_J;
                ctrl.jump      = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.aluop     = ALU_RTYPE;
                ctrl.rd_src    = RD_PC4;
            end
            OPC_JALR: begin
                uses_rs1       = 1'b1;
                ctrl.imm_type  = IMM_I;
                ctrl.jalr      = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.rd_src    = RD_PC4;
                illegal        = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                uses_rs1        = 1'b1;
                uses_rs2        = 1'b1;
                ctrl.imm_type   = IMM_B;
                ctrl.branch     = 1'b1;
                ctrl.aluop      = ALU_BRANCH;
                ctrl.branch_inv = (funct3 == 3'b000) || (funct3 == 3'b100) || (funct3 == 3'b110);
                illegal         = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OPC_LOAD: begin
                uses_rs1       = 1'b1;
                ctrl.imm_type  = IMM_I;
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.rd_src    = RD_MEM;
                ctrl.chip_sel  = 1'b1;
                case (funct3)
                    3'b000:  ctrl.load = LD_LB;
                    3'b001:  ctrl.load = LD_LH;
                    3'b010:  ctrl.load = LD_LW;
                    3'b100:  ctrl.load = LD_LBU;
                    3'b101:  ctrl.load = LD_LHU;
                    default: illegal = 1'b1;
                endcase
            end
            OPC_STORE: begin
                uses_rs1      = 1'b1;
                uses_rs2      = 1'b1;
                ctrl.imm_type = IMM_S;
                ctrl.alu_src  = 1'b1;
                ctrl.chip_sel = 1'b1;
                // mem_web is active-low byte enables
                case (funct3)
                    3'b000: begin ctrl.store = ST_SB; ctrl.mem_web = 4'b1110; end
                    3'b001: begin ctrl.store = ST_SH; ctrl.mem_web = 4'b1100; end
                    3'b010: begin ctrl.store = ST_SW; ctrl.mem_web = 4'b0000; end
                    default: illegal = 1'b1;
                endcase
            end
            OPC_OPIMM: begin
                uses_rs1       = 1'b1;
                ctrl.imm_type  = IMM_I;
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.aluop     = ALU_ITYPE;
            end
            OPC_OP: begin
                uses_rs1       = 1'b1;
                uses_rs2       = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.aluop     = ALU_RTYPE;
                case (funct7)
                    7'b0000000: ;
                    7'b0100000: illegal = !((funct3 == 3'b000) || (funct3 == 3'b101));
`ifdef CTRL_MEXT_EN
                    7'b0000001: ctrl.mul_op = 1'b1;
`endif
                    default:    illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            ctrl = CTRL_BUBBLE;
        end
    end

endmodule

// File: rtl/id_ctrl_stage.sv
// Registered ID/EX control stage: decode, valid/ready handshake, load-use hazard,
// flush and saturating illegal counter. CTRL_MEXT_EN enables M-extension decode.
module id_ctrl_stage
    import ctrl_pkg::*;
#(
    parameter int PC_W      = 32,
    parameter int ILL_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_inst,
    input  logic [PC_W-1:0]      in_pc,
    input  logic                 flush,
    input  logic                 ex_ready,
    output logic                 out_valid,
    output ctrl_t                out_ctrl,
    output logic [PC_W-1:0]      out_pc,
    output logic [4:0]           out_rs1,
    output logic [4:0]           out_rs2,
    output logic [4:0]           out_rd,
    output logic [2:0]           out_funct3,
    output logic                 out_illegal,
    output logic                 hazard_stall,
    output logic [ILL_CNT_W-1:0] ill_count
);

    ctrl_t dec_ctrl;
    logic  dec_illegal;
    logic  dec_uses_rs1;
    logic  dec_uses_rs2;
    logic  advance;
    logic  hazard;
    logic  rs_match;

    ctrl_decode u_decode (
        .inst     (in_inst),
        .ctrl     (dec_ctrl),
        .illegal  (dec_illegal),
        .uses_rs1 (dec_uses_rs1),
        .uses_rs2 (dec_uses_rs2)
    );

    assign advance  = !out_valid || ex_ready;
    assign rs_match = (dec_uses_rs1 && (in_inst[19:15] == out_rd)) ||
                      (dec_uses_rs2 && (in_inst[24:20] == out_rd));
    assign hazard   = out_valid && out_ctrl.mem_read && (out_rd != '0) && in_valid && rs_match;

    // Flush consumes and discards the incoming instruction even under a hazard.
    assign in_ready     = flush || (advance && !hazard);
    assign hazard_stall = hazard;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_ctrl    <= CTRL_BUBBLE;
            out_pc      <= '0;
            out_rs1     <= '0;
            out_rs2     <= '0;
            out_rd      <= '0;
            out_funct3  <= '0;
            out_illegal <= 1'b0;
            ill_count   <= '0;
        end else begin
            if (flush || (advance && !(in_valid && !hazard))) begin
                out_valid   <= 1'b0;
                out_ctrl    <= CTRL_BUBBLE;
                out_pc      <= '0;
                out_rs1     <= '0;
                out_rs2     <= '0;
                out_rd      <= '0;
                out_funct3  <= '0;
                out_illegal <= 1'b0;
            end else if (advance) begin
                out_valid   <= 1'b1;
                out_ctrl    <= dec_ctrl;
                out_pc      <= in_pc;
                out_rs1     <= in_inst[19:15];
                out_rs2     <= in_inst[24:20];
                out_rd      <= in_inst[11:7];
                out_funct3  <= in_inst[14:12];
                out_illegal <= dec_illegal;
            end
            if (in_valid && in_ready && !flush && dec_illegal && (ill_count != '1)) begin
                ill_count <= ill_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_id_ctrl_stage.sv
// Randomized self-checking bench for id_ctrl_stage against a field-level reference model.
// Expectations for the M-extension case follow CTRL_MEXT_EN.
module tb_id_ctrl_stage;
    import ctrl_pkg::*;

    localparam int PC_W      = 32;
    localparam int ILL_CNT_W = 8;
    localparam int CNT_MAX   = (1 << ILL_CNT_W) - 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [31:0]          in_inst = '0;
    logic [PC_W-1:0]      in_pc = '0;
    logic                 flush = 1'b0;
    logic                 ex_ready = 1'b1;
    logic                 out_valid;
    ctrl_t                out_ctrl;
    logic [PC_W-1:0]      out_pc;
    logic [4:0]           out_rs1, out_rs2, out_rd;
    logic [2:0]           out_funct3;
    logic                 out_illegal;
    logic                 hazard_stall;
    logic [ILL_CNT_W-1:0] ill_count;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    id_ctrl_stage #(.PC_W(PC_W), .ILL_CNT_W(ILL_CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_inst      (in_inst),
        .in_pc        (in_pc),
        .flush        (flush),
        .ex_ready     (ex_ready),
        .out_valid    (out_valid),
        .out_ctrl     (out_ctrl),
        .out_pc       (out_pc),
        .out_rs1      (out_rs1),
        .out_rs2      (out_rs2),
        .out_rd       (out_rd),
        .out_funct3   (out_funct3),
        .out_illegal  (out_illegal),
        .hazard_stall (hazard_stall),
        .ill_count    (ill_count)
    );

    typedef struct packed {
        logic                 valid;
        ctrl_t                ctrl;
        logic [PC_W-1:0]      pc;
        logic [4:0]           rs1, rs2, rd;
        logic [2:0]           f3;
        logic                 ill;
        logic [ILL_CNT_W-1:0] cnt;
    } obs_t;

    obs_t dut_obs;
    assign dut_obs = {out_valid, out_ctrl, out_pc, out_rs1, out_rs2, out_rd, out_funct3, out_illegal, ill_count};

    // ---------------- reference model ----------------
    bit              m_valid;
    ctrl_t           m_ctrl;
    logic [PC_W-1:0] m_pc;
    logic [4:0]      m_rs1, m_rs2, m_rd;
    logic [2:0]      m_f3;
    bit              m_ill;
    int              m_cnt;

    function automatic ctrl_t ref_bubble();
        ctrl_t c;
        c          = '0;
        c.mem_web  = 4'hF;
        c.imm_type = imm_type_e'(3'd7);
        return c;
    endfunction

    function automatic void ref_decode(input logic [31:0] i, output ctrl_t c, output bit ill,
                                       output bit u1, output bit u2);
        logic [6:0] op, f7;
        logic [2:0] f3, it;
        logic [1:0] ao, rs;
        bit lui, auipc, jal, jalr, br, ld, st, opi, opr, known, mext;
        logic [2:0] ld_lut [8];
        ld_lut = '{3'd1, 3'd2, 3'd5, 3'd0, 3'd3, 3'd4, 3'd0, 3'd0};
        op = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
        lui = (op == 7'h37); auipc = (op == 7'h17); jal = (op == 7'h6F); jalr = (op == 7'h67);
        br  = (op == 7'h63); ld = (op == 7'h03); st = (op == 7'h23); opi = (op == 7'h13);
        opr = (op == 7'h33);
        known = lui | auipc | jal | jalr | br | ld | st | opi | opr;
`ifdef CTRL_MEXT_EN
        mext = 1'b1;
`else
        mext = 1'b0;
`endif
        ill = !known || (ld && (f3 inside {3'd3, 3'd6, 3'd7})) || (st && f3 > 3'd2) ||
              (br && (f3 inside {3'd2, 3'd3})) || (jalr && f3 != 3'd0) ||
              (opr && !((f7 == 7'h00) || (f7 == 7'h20 && (f3 inside {3'd0, 3'd5})) || (mext && f7 == 7'h01)));
        u1 = known && !(lui || auipc || jal);
        u2 = opr || st || br;
        c  = ref_bubble();
        if (!ill) begin
            it = opr ? 3'd7 : st ? 3'd2 : br ? 3'd3 : (lui || auipc) ? 3'd4 : jal ? 3'd5 : 3'd1;
            ao = (ld || st || jalr) ? 2'd0 : br ? 2'd1 : opi ? 2'd3 : 2'd2;
            rs = ld ? 2'd1 : (jal || jalr) ? 2'd2 : (lui || auipc) ? 2'd3 : 2'd0;
            c.imm_type   = imm_type_e'(it);
            c.jump       = jal;
            c.branch     = br;
            c.jalr       = jalr;
            c.mem_read   = ld;
            c.mem_web    = !st ? 4'hF : (f3 == 3'd0) ? 4'hE : (f3 == 3'd1) ? 4'hC : 4'h0;
            c.alu_src    = lui | auipc | jalr | ld | st | opi;
            c.reg_write  = !(br || st);
            c.aluop      = aluop_e'(ao);
            c.mul_op     = opr && (f7 == 7'h01);
            c.rd_src     = rd_src_e'(rs);
            c.pc_imm     = auipc;
            c.chip_sel   = ld | st;
            c.branch_inv = br && (f3 inside {3'd0, 3'd4, 3'd6});
            c.store      = st ? 2'(f3 + 3'd1) : 2'd0;
            c.load       = ld ? ld_lut[f3] : 3'd0;
        end
    endfunction

    function automatic void model_clear();
        m_valid = 0; m_ctrl = ref_bubble(); m_pc = '0;
        m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_f3 = '0; m_ill = 0;
    endfunction

    function automatic bit model_hazard();
        ctrl_t c; bit ill, u1, u2;
        ref_decode(in_inst, c, ill, u1, u2);
        return m_valid && m_ctrl.mem_read && (m_rd != 0) && in_valid &&
               ((u1 && in_inst[19:15] == m_rd) || (u2 && in_inst[24:20] == m_rd));
    endfunction

    function automatic bit model_ready();
        return flush || ((!m_valid || ex_ready) && !model_hazard());
    endfunction

    function automatic void model_clock();
        ctrl_t c; bit ill, u1, u2, hz, adv;
        ref_decode(in_inst, c, ill, u1, u2);
        hz  = model_hazard();
        adv = !m_valid || ex_ready;
        if (in_valid && !flush && adv && !hz && ill && m_cnt < CNT_MAX) m_cnt++;
        if (flush) model_clear();
        else if (adv) begin
            if (in_valid && !hz) begin
                m_valid = 1; m_ctrl = c; m_pc = in_pc; m_rs1 = in_inst[19:15];
                m_rs2 = in_inst[24:20]; m_rd = in_inst[11:7]; m_f3 = in_inst[14:12]; m_ill = ill;
            end else model_clear();
        end
    endfunction

    function automatic obs_t model_obs();
        return {m_valid, m_ctrl, m_pc, m_rs1, m_rs2, m_rd, m_f3, m_ill, ILL_CNT_W'(m_cnt)};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit v, input logic [31:0] i, input bit fl, input bit er);
        @(negedge clk);
        in_valid = v; in_inst = i; in_pc = $urandom; flush = fl; ex_ready = er;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    function automatic logic [31:0] rand_legal_or_not();
        logic [6:0] ops [9];
        logic [6:0] f7s [4];
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
        f7s = '{7'h00, 7'h00, 7'h20, 7'h01};
        if ($urandom_range(0, 9) == 0) return $urandom;
        return {f7s[$urandom_range(0, 3)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                3'($urandom_range(0, 7)), 5'($urandom_range(0, 3)), ops[$urandom_range(0, 8)]};
    endfunction

    function automatic logic [31:0] rand_illegal();
        logic [31:0] w;
        int r;
        w = $urandom;
        case ($urandom_range(0, 7))
            0: w[1:0] = 2'($urandom_range(0, 2));
            1: begin r = $urandom_range(0, 2); w[6:0] = 7'h03; w[14:12] = (r == 0) ? 3'd3 : (r == 1) ? 3'd6 : 3'd7; end
            2: begin w[6:0] = 7'h23; w[14:12] = 3'($urandom_range(3, 7)); end
            3: begin w[6:0] = 7'h63; w[14:12] = 3'($urandom_range(2, 3)); end
            4: begin w[6:0] = 7'h67; w[14:12] = 3'($urandom_range(1, 7)); end
            5: begin r = $urandom_range(1, 6); w[6:0] = 7'h33; w[31:25] = 7'h20; w[14:12] = 3'((r < 5) ? r : r + 1); end
            6: begin w[6:0] = 7'h33; w[31:25] = 7'h40; end
            default: w[6:0] = 7'h7F;
        endcase
        return w;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_inst = 32'h00500093; ex_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_clear(); m_cnt = 0;
        n_cmp++;
        if (dut_obs !== model_obs()) begin n_fail++; $display("FAIL reset_state: got %h want %h", dut_obs, model_obs()); end
        n_cmp++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_addi_stream();
        logic [31:0] w;
        logic [PC_W-1:0] pc;
        drive(0, '0, 0, 1); tick();
        for (int k = 0; k < 8; k++) begin
            w = {12'($urandom), 5'($urandom), 3'b000, 5'($urandom), 7'h13};
            drive(1, w, 0, 1);
            pc = in_pc;
            n_cmp++;
            if (in_ready !== 1'b1) begin n_fail++; $display("FAIL addi_in_ready: got %b want 1", in_ready); end
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || out_pc !== pc || out_ctrl.aluop !== ALU_ITYPE ||
                out_ctrl.alu_src !== 1'b1 || out_ctrl.reg_write !== 1'b1) begin
                n_fail++;
                $display("FAIL addi_fields: got v=%b pc=%h aluop=%0d src=%b rw=%b want v=1 pc=%h aluop=3 src=1 rw=1",
                         out_valid, out_pc, out_ctrl.aluop, out_ctrl.alu_src, out_ctrl.reg_write, pc);
            end
            n_cmp++;
            if (dut_obs !== model_obs()) begin n_fail++; $display("FAIL addi_model: got %h want %h", dut_obs, model_obs()); end
        end
    endtask

    task automatic test_load_use();
        logic [31:0] lw_x5, add_x6;
        lw_x5  = {12'h004, 5'd1, 3'b010, 5'd5, 7'h03};
        add_x6 = {7'd0, 5'd1, 5'd5, 3'b000, 5'd6, 7'h33};
        drive(1, lw_x5, 0, 1); tick();
        drive(1, add_x6, 0, 1);
        n_cmp++;
        if (hazard_stall !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL loaduse_stall: got hz=%b rdy=%b want hz=1 rdy=0", hazard_stall, in_ready);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || out_ctrl.reg_write !== 1'b0) begin
            n_fail++; $display("FAIL loaduse_bubble: got v=%b rw=%b want v=0 rw=0", out_valid, out_ctrl.reg_write);
        end
        drive(1, add_x6, 0, 1);
        n_cmp++;
        if (hazard_stall !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL loaduse_release: got hz=%b rdy=%b want hz=0 rdy=1", hazard_stall, in_ready);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_rd !== 5'd6 || out_rs1 !== 5'd5) begin
            n_fail++; $display("FAIL loaduse_add: got v=%b rd=%0d rs1=%0d want v=1 rd=6 rs1=5", out_valid, out_rd, out_rs1);
        end
        n_cmp++;
        if (dut_obs !== model_obs()) begin n_fail++; $display("FAIL loaduse_model: got %h want %h", dut_obs, model_obs()); end
    endtask

    task automatic test_backpressure_and_flush();
        logic [31:0] bne;
        obs_t held;
        int cnt_before;
        bne = {7'($urandom), 5'd2, 5'd1, 3'b001, 5'($urandom), 7'h63};
        drive(1, bne, 0, 1); tick();
        held = model_obs();
        n_cmp++;
        if (out_ctrl.branch !== 1'b1 || out_ctrl.branch_inv !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL bne_fields: got br=%b inv=%b v=%b want br=1 inv=0 v=1",
                               out_ctrl.branch, out_ctrl.branch_inv, out_valid);
        end
        for (int k = 0; k < 3; k++) begin
            drive(1, {12'($urandom), 5'd3, 3'b000, 5'd4, 7'h13}, 0, 0);
            n_cmp++;
            if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
            tick();
            n_cmp++;
            if (dut_obs !== held) begin n_fail++; $display("FAIL bp_hold: got %h want %h", dut_obs, held); end
        end
        cnt_before = m_cnt;
        drive(1, 32'h0000_0000, 1, 0);
        n_cmp++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || ill_count !== ILL_CNT_W'(cnt_before) || out_ctrl !== ref_bubble()) begin
            n_fail++; $display("FAIL flush_drop: got v=%b cnt=%0d ctrl=%h want v=0 cnt=%0d ctrl=%h",
                               out_valid, ill_count, out_ctrl, cnt_before, ref_bubble());
        end
        // flush coinciding with a load-use hazard
        drive(1, {12'h010, 5'd2, 3'b010, 5'd7, 7'h03}, 0, 1); tick();
        drive(1, {7'd0, 5'd7, 5'd7, 3'b000, 5'd8, 7'h33}, 1, 1);
        n_cmp++;
        if (hazard_stall !== 1'b1 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL flush_hazard: got hz=%b rdy=%b want hz=1 rdy=1", hazard_stall, in_ready);
        end
        tick();
        n_cmp++;
        if (dut_obs !== model_obs() || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_hazard_state: got %h want %h", dut_obs, model_obs());
        end
    endtask

    task automatic test_illegal_count();
        @(negedge clk);
        rst = 1'b1; #1;
        model_clear(); m_cnt = 0;
        n_cmp++;
        if (dut_obs !== model_obs()) begin n_fail++; $display("FAIL ill_reset: got %h want %h", dut_obs, model_obs()); end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 301; k++) begin
            drive(1, (k == 0) ? 32'h0 : rand_illegal(), 0, 1);
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_ctrl !== ref_bubble() ||
                ill_count !== ILL_CNT_W'((k + 1 > CNT_MAX) ? CNT_MAX : k + 1)) begin
                n_fail++; $display("FAIL ill_count_%0d: got v=%b ill=%b ctrl=%h cnt=%0d want v=1 ill=1 ctrl=%h cnt=%0d",
                                   k, out_valid, out_illegal, out_ctrl, ill_count, ref_bubble(),
                                   (k + 1 > CNT_MAX) ? CNT_MAX : k + 1);
            end
        end
        n_cmp++;
        if (ill_count !== 8'd255) begin n_fail++; $display("FAIL ill_saturate: got %0d want 255", ill_count); end
        drive(1, 32'h0, 0, 1);
        rst = 1'b1; #1;
        model_clear(); m_cnt = 0;
        n_cmp++;
        if (dut_obs !== model_obs()) begin n_fail++; $display("FAIL ill_async_reset: got %h want %h", dut_obs, model_obs()); end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_mul();
        bit exp_mul, exp_ill;
`ifdef CTRL_MEXT_EN
        exp_mul = 1'b1; exp_ill = 1'b0;
`else
        exp_mul = 1'b0; exp_ill = 1'b1;
`endif
        drive(0, '0, 0, 1); tick();
        drive(1, 32'h0220_8033, 0, 1); tick();
        n_cmp++;
        if (out_ctrl.mul_op !== exp_mul || out_illegal !== exp_ill || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL mul: got mul=%b ill=%b v=%b want mul=%b ill=%b v=1",
                               out_ctrl.mul_op, out_illegal, out_valid, exp_mul, exp_ill);
        end
    endtask

    task automatic test_random();
        bit er, hz;
        for (int k = 0; k < 600; k++) begin
            er = ($urandom_range(0, 3) != 0);
            drive($urandom_range(0, 3) != 0, rand_legal_or_not(), $urandom_range(0, 15) == 0, er);
            hz = model_hazard();
            n_cmp++;
            if (in_ready !== model_ready() || hazard_stall !== hz) begin
                n_fail++; $display("FAIL rand_comb_%0d: got rdy=%b hz=%b want rdy=%b hz=%b",
                                   k, in_ready, hazard_stall, model_ready(), hz);
            end
            tick();
            n_cmp++;
            if (dut_obs !== model_obs()) begin
                n_fail++; $display("FAIL rand_state_%0d: got %h want %h", k, dut_obs, model_obs());
            end
        end
    endtask

    initial begin
        test_reset();
        test_addi_stream();
        test_load_use();
        test_backpressure_and_flush();
        test_mul();
        test_random();
        test_illegal_count();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ctrl_stage.md
# id_ctrl_stage

Registered instruction-decode control stage for the RV32I core. It decodes each 32-bit instruction into the team's control bundle and holds it in an ID/EX pipeline register behind a valid/ready handshake. It also detects load-use hazards against the instruction it currently holds, handles pipeline flushes, flags illegal instructions and counts them. It sits between the IF/ID register and the EX stage and replaces the purely combinational control decode.

## Interface
- `PC_W`, 32, PC width
- `ILL_CNT_W`, 8, width of the saturating illegal-instruction counter
- `clk`  in  1  clock; every register samples on the rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `in_valid`  in  1  IF/ID presents an instruction
- `in_ready`  out  1  stage accepts the instruction this cycle
- `in_inst`  in  32  instruction word
- `in_pc`  in  PC_W  PC of the instruction
- `flush`  in  1  kill the incoming instruction and the held instruction (taken branch or jump resolved in EX)
- `ex_ready`  in  1  EX can take the held instruction
- `out_valid`  out  1  held instruction is valid
- `out_ctrl`  out  ctrl_t  registered control bundle
- `out_pc`  out  PC_W  registered PC
- `out_rs1`, `out_rs2`, `out_rd`  out  5 each  registered register indices
- `out_funct3`  out  3  registered funct3
- `out_illegal`  out  1  held instruction is illegal
- `hazard_stall`  out  1  combinational load-use stall indication
- `ill_count`  out  ILL_CNT_W  number of accepted illegal instructions, saturating

## Operation
- **ctrl_t fields and encodings**
  - imm_type: 1 I, 2 S, 3 B, 4 U, 5 J, 7 none
  - jump, branch, jalr, mem_read
  - mem_web[3:0], active-low, idle value 4'b1111
  - alu_src
  - reg_write
  - aluop: 00 load/store/JALR, 01 branch, 10 R/LUI/AUIPC/JAL, 11 I-ALU
  - mul_op
  - rd_src: 00 ALU, 01 mem, 10 PC+4, 11 PC+Imm or Imm
  - pc_imm
  - chip_sel
  - branch_inv: 1 for funct3 000/100/110, 0 for 001/101/111
  - store: 01 SB, 10 SH, 11 SW, 00 none
  - load: 101 LW, 001 LB, 010 LH, 011 LBU, 100 LHU, 000 none
- **Bubble value:** all control fields zero, except mem_web = 4'b1111 and imm_type = 7.
- **Illegal instructions:** an instruction is illegal if any of the following holds. The stage then holds the bubble value with out_illegal = 1.
  - inst[1:0] != 2'b11
  - unknown opcode
  - load funct3 is 011, 110 or 111
  - store funct3 > 010
  - branch funct3 is 010 or 011
  - JALR funct3 != 000
  - R-type funct7 not 0000000; 0100000 is accepted only with funct3 000 or 101
- **Advance:** advance = !out_valid || ex_ready.
- **Hazard:** hazard = out_valid && out_ctrl.mem_read && out_rd != 0 && in_valid && a used source register equals out_rd.
  - rs1 is used by every opcode except LUI, AUIPC and JAL.
  - rs2 is used by R, S and B types.
- **Input ready:** in_ready = advance && !hazard. hazard_stall = hazard.
- **Register update on advance, when no flush is active:**
  - out_valid <= in_valid && !hazard
  - the payload is loaded with the decoded instruction
  - if in_valid is low or hazard is set, a bubble is loaded instead
- **Flush:** takes priority over everything else.
  - Next state is out_valid = 0 with the bubble payload, regardless of ex_ready.
  - in_ready = 1 during flush, so the incoming instruction is consumed and discarded.
- **Illegal counter:** ill_count increments on in_valid && in_ready && !flush && illegal, and saturates at all-ones.

## Timing
- Latency is 1 cycle from acceptance to out_valid.
- Sustained throughput is 1 instruction per cycle when ex_ready = 1 and no hazard is present.
- A load-use hazard costs exactly 1 bubble cycle: the load leaves the stage, the stage goes empty, and the dependent instruction is accepted the following cycle.
- When ex_ready = 0 and out_valid = 1, every output holds stable.
- Reset values:
  - out_valid = 0, out_illegal = 0, ill_count = 0
  - out_ctrl = bubble
  - out_pc, out_rs1, out_rs2, out_rd, out_funct3 = 0
- An in-flight instruction is lost on reset. No partial state survives.
- Flush in the same cycle as hazard: the flush wins and in_ready = 1.
- A stage that is empty and holds a load never produces a hazard, because hazard requires out_valid.

## Configuration
- `CTRL_MEXT_EN` defined: opcode 0110011 with funct7 0000001 is legal and decodes as R-type with mul_op = 1.
- `CTRL_MEXT_EN` undefined: that encoding is illegal, and mul_op is tied to 0.

## Structure
- The package `ctrl_pkg` holds:
  - ctrl_t
  - opcode localparams
  - imm_type, aluop and rd_src enums
  - load and store codes
  - the CTRL_BUBBLE constant
- The sub-module `ctrl_decode` is purely combinational. It maps inst to {ctrl_t, illegal, uses_rs1, uses_rs2}.
- `id_ctrl_stage` contains the handshake, hazard logic, pipeline register and counter.

## Test plan
- **ADDI stream:** back-to-back ADDI with ex_ready = 1 → one instruction per cycle, aluop = 11, alu_src = 1, reg_write = 1.
- **Load-use:** LW x5 then ADD x6,x5,x1 → hazard_stall = 1 and in_ready = 0 for one cycle; the bubble has reg_write = 0; ADD emerges on the next cycle.
- **Backpressure:** ex_ready = 0 for 3 cycles holding BNE → outputs stable with branch = 1, branch_inv = 0; in_ready = 0.
- **Flush:** flush with out_valid = 1 and ex_ready = 0 → out_valid = 0 next cycle; the incoming instruction is dropped; ill_count is unchanged.
- **Illegal counting:** inst 0x00000000, then 300 illegal instructions with ILL_CNT_W = 8 → out_illegal = 1 each time with the bubble ctrl; ill_count saturates at 255.
- **MUL (0x02208033):** out_ctrl.mul_op = 1 with CTRL_MEXT_EN defined; out_illegal = 1 without it.
